// File: rtl/ofdm_subcarrier_scheduler_if.sv
// Stream bundle for the subcarrier scheduler: QAM symbol input handshake and
// tagged IFFT-loader output beat. master = scheduler side, slave = neighbours.
interface ofdm_subcarrier_scheduler_if #(
  parameter int BW = 6
);
  logic [5:0]    data_sym;
  logic          data_valid;
  logic          data_ready;

  logic [5:0]    out_sym;
  logic [1:0]    out_type;
  logic          out_pilot_neg;
  logic [BW-1:0] out_bin;
  logic          out_sof;
  logic          out_eof;
  logic          out_valid;
  logic          out_ready;

  modport master (
    input  data_sym, data_valid, out_ready,
    output data_ready, out_sym, out_type, out_pilot_neg, out_bin,
           out_sof, out_eof, out_valid
  );

  modport slave (
    output data_sym, data_valid, out_ready,
    input  data_ready, out_sym, out_type, out_pilot_neg, out_bin,
           out_sof, out_eof, out_valid
  );
endinterface

// File: rtl/ofdm_subcarrier_scheduler.sv
// Walks one OFDM symbol bin by bin, classifying null/pilot/data bins, pulling QAM
// codes only for data bins, and leaving a CP_LEN-cycle gap between symbols.
module ofdm_subcarrier_scheduler #(
  parameter int FFT_SIZE      = 64,
  parameter int NUM_USED      = 52,
  parameter int PILOT_SPACING = 14,
  parameter int PILOT_OFFSET  = 7,
  parameter int CP_LEN        = 16,
  parameter int BW            = $clog2(FFT_SIZE)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  ofdm_subcarrier_scheduler_if.master bus,
  output logic                        busy,
  output logic [15:0]                 frame_cnt
);

  localparam int PW = (PILOT_SPACING > 1) ? $clog2(PILOT_SPACING) : 1;
  localparam int GW = (CP_LEN > 1) ? $clog2(CP_LEN) : 1;

  localparam logic [BW-1:0] BIN_LAST    = BW'(FFT_SIZE - 1);
  localparam logic [BW-1:0] USED_LO     = BW'(NUM_USED / 2);
  localparam logic [BW-1:0] USED_HI     = BW'(FFT_SIZE - NUM_USED / 2);
  localparam logic [PW-1:0] PHASE_LAST  = PW'(PILOT_SPACING - 1);
  localparam logic [PW-1:0] PHASE_PILOT = PW'(PILOT_OFFSET);
  localparam logic [GW-1:0] GAP_LAST    = GW'((CP_LEN > 0) ? CP_LEN - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state_reg;
  logic [BW-1:0] bin_reg;
  logic [PW-1:0] phase_reg;
  logic [GW-1:0] gap_reg;
  logic [6:0]    lfsr_reg;
  logic [6:0]    lfsr_next;
  logic [15:0]   frame_cnt_reg;

  logic [5:0]    out_sym_reg;
  logic [1:0]    out_type_reg;
  logic          out_pilot_neg_reg;
  logic [BW-1:0] out_bin_reg;
  logic          out_sof_reg;
  logic          out_eof_reg;
  logic          out_valid_reg;

  logic          slot_free;
  logic          in_fill;
  logic          is_null;
  logic          is_pilot;
  logic          is_data;
  logic          last_bin;
  logic          load;
  logic [1:0]    load_type;

  // phase_reg tracks bin mod PILOT_SPACING, so no divider is needed
  always_comb begin
    slot_free = !out_valid_reg || bus.out_ready;
    in_fill   = (state_reg == FILL);
    is_null   = (bin_reg == '0) || ((bin_reg > USED_LO) && (bin_reg < USED_HI));
    is_pilot  = !is_null && (phase_reg == PHASE_PILOT);
    is_data   = !is_null && !is_pilot;
    last_bin  = (bin_reg == BIN_LAST);
    load      = in_fill && slot_free && (!is_data || bus.data_valid);
    load_type = 2'd0;
    if (is_pilot) begin
      load_type = 2'd2;
    end else if (is_data) begin
      load_type = 2'd1;
    end
  end

  // x^7 + x^4 + 1 style scrambler step for the per-frame pilot polarity
  assign lfsr_next[0] = lfsr_reg[6] ^ lfsr_reg[3];
  for (genvar gi = 1; gi < 7; gi++) begin : g_lfsr
    assign lfsr_next[gi] = lfsr_reg[gi-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg         <= IDLE;
      bin_reg           <= '0;
      phase_reg         <= '0;
      gap_reg           <= '0;
      lfsr_reg          <= 7'h7F;
      frame_cnt_reg     <= 16'd0;
      out_sym_reg       <= 6'd0;
      out_type_reg      <= 2'd0;
      out_pilot_neg_reg <= 1'b0;
      out_bin_reg       <= '0;
      out_sof_reg       <= 1'b0;
      out_eof_reg       <= 1'b0;
      out_valid_reg     <= 1'b0;
    end else begin
      // The output slot drains in any state; only FILL ever refills it.
      if (slot_free) begin
        out_valid_reg <= load;
        if (load) begin
          out_sym_reg  <= is_data ? bus.data_sym : 6'd0;
          out_type_reg <= load_type;
          out_bin_reg  <= bin_reg;
          out_sof_reg  <= (bin_reg == '0);
          out_eof_reg  <= last_bin;
          if (bin_reg == '0) begin
            out_pilot_neg_reg <= lfsr_reg[0];
          end
        end
      end

      unique case (state_reg)
        IDLE: begin
          if (enable) begin
            state_reg <= FILL;
            bin_reg   <= '0;
            phase_reg <= '0;
          end
        end
        FILL: begin
          if (load) begin
            if (last_bin) begin
              bin_reg       <= '0;
              phase_reg     <= '0;
              gap_reg       <= '0;
              frame_cnt_reg <= frame_cnt_reg + 16'd1;
              lfsr_reg      <= lfsr_next;
              if (CP_LEN > 0) begin
                state_reg <= GAP;
              end else if (!enable) begin
                state_reg <= IDLE;
              end
            end else begin
              bin_reg   <= bin_reg + 1'b1;
              phase_reg <= (phase_reg == PHASE_LAST) ? '0 : phase_reg + 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_reg == GAP_LAST) begin
            gap_reg   <= '0;
            state_reg <= enable ? FILL : IDLE;
          end else begin
            gap_reg <= gap_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.data_ready    = in_fill && slot_free && is_data;
  assign bus.out_sym       = out_sym_reg;
  assign bus.out_type      = out_type_reg;
  assign bus.out_pilot_neg = out_pilot_neg_reg;
  assign bus.out_bin       = out_bin_reg;
  assign bus.out_sof       = out_sof_reg;
  assign bus.out_eof       = out_eof_reg;
  assign bus.out_valid     = out_valid_reg;
  assign busy              = (state_reg != IDLE);
  assign frame_cnt         = frame_cnt_reg;

endmodule

// File: tb/tb_ofdm_subcarrier_scheduler.sv
// Directed-plus-random bench for ofdm_subcarrier_scheduler against a bin-level
// reference model (bin classes, symbol queue, per-frame polarity).
module tb_ofdm_subcarrier_scheduler;
  localparam int FFT_SIZE      = 64;
  localparam int NUM_USED      = 52;
  localparam int PILOT_SPACING = 14;
  localparam int PILOT_OFFSET  = 7;
  localparam int CP_LEN        = 16;
  localparam int BW            = $clog2(FFT_SIZE);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        busy;
  logic [15:0] frame_cnt;

  ofdm_subcarrier_scheduler_if #(.BW(BW)) bus ();

  ofdm_subcarrier_scheduler #(
    .FFT_SIZE(FFT_SIZE), .NUM_USED(NUM_USED), .PILOT_SPACING(PILOT_SPACING),
    .PILOT_OFFSET(PILOT_OFFSET), .CP_LEN(CP_LEN), .BW(BW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int         exp_bin;
  logic [5:0] symq[$];
  logic [6:0] lfsr_m;
  int         frames_done;
  logic       frame_pol;
  int         beats_in_frame;
  int         data_in_frame;
  logic       pol_hist[$];
  logic [5:0] frame_sym[FFT_SIZE];
  logic [1:0] frame_type[FFT_SIZE];

  // per-cycle bookkeeping
  int          cyc = 0;
  int          sof_cyc = 0;
  int          eof_cyc = 0;
  int          mode = 0;
  logic        prev_slot_free;
  logic        prev_acc;
  logic        exp_new_known;
  logic        exp_new;
  logic        new_beat;
  logic [31:0] last_vec;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_type(input int k);
    if (k == 0 || (k > NUM_USED / 2 && k < FFT_SIZE - NUM_USED / 2)) return 0;
    if (k % PILOT_SPACING == PILOT_OFFSET) return 2;
    return 1;
  endfunction

  task automatic model_reset();
    exp_bin        = 0;
    symq.delete();
    lfsr_m         = 7'h7F;
    frames_done    = 0;
    frame_pol      = 1'b0;
    beats_in_frame = 0;
    data_in_frame  = 0;
    prev_slot_free = 1'b1;
    prev_acc       = 1'b0;
    exp_new_known  = 1'b0;
    exp_new        = 1'b0;
    new_beat       = 1'b0;
    last_vec       = '0;
  endtask

  task automatic monitor();
    logic [31:0] vec;
    logic [31:0] ev;
    logic [5:0]  es;
    int          t;
    vec = {15'b0, bus.out_sof, bus.out_eof, bus.out_pilot_neg, bus.out_type,
           bus.out_sym, bus.out_bin};
    new_beat = bus.out_valid && prev_slot_free;
    if (!prev_slot_free) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_beat", vec, last_vec);
    end
    if (exp_new_known) check("beat_load", new_beat, exp_new);
    if (prev_acc) check("latency", new_beat && bus.out_type == 2'd1, 1);
    if (new_beat) begin
      t  = ref_type(exp_bin);
      es = 6'd0;
      if (t == 1) begin
        check("sym_available", symq.size() > 0, 1);
        if (symq.size() > 0) es = symq.pop_front();
      end
      if (exp_bin == 0) begin
        frame_pol      = lfsr_m[0];
        beats_in_frame = 0;
        data_in_frame  = 0;
        sof_cyc        = cyc;
        pol_hist.push_back(frame_pol);
      end
      ev = {15'b0, exp_bin == 0, exp_bin == FFT_SIZE - 1, frame_pol, 2'(t), es, BW'(exp_bin)};
      check("beat", vec, ev);
      frame_sym[exp_bin]  = bus.out_sym;
      frame_type[exp_bin] = bus.out_type;
      beats_in_frame++;
      if (t == 1) data_in_frame++;
      if (exp_bin == FFT_SIZE - 1) begin
        eof_cyc = cyc;
        frames_done++;
        lfsr_m = {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[3]};
        check("frame_beats", beats_in_frame, FFT_SIZE);
        check("frame_data", data_in_frame, 48);
      end
      exp_bin = (exp_bin + 1) % FFT_SIZE;
      check("frame_cnt", frame_cnt, 16'(frames_done));
    end
    last_vec = vec;
  endtask

  // One clock: inputs applied now, handshake sampled at negedge, outputs at posedge+1.
  task automatic step();
    logic sf;
    logic dr;
    if (mode != 0) bus.data_sym = 6'($urandom);
    if (mode == 2) begin
      bus.data_valid = ($urandom_range(0, 3) != 0);
      bus.out_ready  = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    sf = !bus.out_valid || bus.out_ready;
    dr = bus.data_ready;
    check("data_ready", dr, sf && exp_bin != 0 && ref_type(exp_bin) == 1);
    if (exp_bin != 0) check("busy_mid_frame", busy, 1);
    prev_acc = bus.data_valid && dr;
    if (prev_acc) symq.push_back(bus.data_sym);
    prev_slot_free = sf;
    exp_new_known  = (exp_bin != 0);
    exp_new        = sf && (ref_type(exp_bin) != 1 || bus.data_valid);
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic run_until_bin(input int b, input int limit, input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(new_beat && bus.out_bin == BW'(b)) && n < limit);
    check(tag, new_beat && bus.out_bin == BW'(b), 1);
  endtask

  task automatic run_until_frames(input int f, input int limit, input string tag);
    int n;
    n = 0;
    while (frames_done < f && n < limit) begin
      step();
      n++;
    end
    check(tag, frames_done, f);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_beat"}, {bus.out_sof, bus.out_eof, bus.out_pilot_neg, bus.out_type,
                           bus.out_sym, bus.out_bin}, 0);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_ready"}, bus.data_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_fcnt"}, frame_cnt, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int ramp;
    int nb_count;
    int n;

    model_reset();
    bus.data_sym   = 6'd0;
    bus.data_valid = 1'b0;
    bus.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst");

    // Frame 1: back-to-back, ramp data
    reset = 1'b1;
    enable = 1'b1;
    bus.data_valid = 1'b1;
    ramp = 0;
    n = 0;
    while (frames_done < 1 && n < 300) begin
      bus.data_sym = 6'(ramp);
      step();
      if (prev_acc) ramp++;
      n++;
    end
    check("frame1_done", frames_done, 1);
    check("ramp_consumed", ramp, 48);
    check("bin1_sym", frame_sym[1], 0);
    check("bin6_sym", frame_sym[6], 5);
    check("bin7_sym", frame_sym[7], 0);
    check("bin7_type", frame_type[7], 2);
    check("bin8_sym", frame_sym[8], 6);
    check("bin21_type", frame_type[21], 2);
    check("bin26_type", frame_type[26], 1);
    check("bin27_type", frame_type[27], 0);
    check("bin37_type", frame_type[37], 0);
    check("bin38_type", frame_type[38], 1);
    check("bin49_type", frame_type[49], 2);
    check("bin63_type", frame_type[63], 2);
    check("back_to_back", eof_cyc - sof_cyc, FFT_SIZE - 1);

    // Gap to frame 2
    mode = 1;
    run_until_bin(0, 100, "frame2_sof");
    check("cp_gap", sof_cyc - eof_cyc, CP_LEN + 1);

    // Output stall at bin 10
    run_until_bin(10, 100, "reach_bin10");
    bus.out_ready = 1'b0;
    repeat (5) begin
      step();
      check("stall_ready", bus.data_ready, 0);
    end
    check("stall_bin", {bus.out_valid, bus.out_bin}, {1'b1, 6'd10});
    bus.out_ready = 1'b1;

    // Input starvation at data bin 12
    run_until_bin(11, 20, "reach_bin11");
    bus.data_valid = 1'b0;
    repeat (3) begin
      step();
      check("starve_valid", bus.out_valid, 0);
    end
    bus.data_valid = 1'b1;
    step();
    check("resume_bin12", {bus.out_valid, bus.out_bin}, {1'b1, 6'd12});

    // Random traffic through frame 3, enable dropped at bin 30 of frame 3
    mode = 2;
    run_until_frames(2, 2000, "frame2_done");
    run_until_bin(30, 2000, "frame3_bin30");
    enable = 1'b0;
    run_until_frames(3, 2000, "frame3_done");
    check("frame_cnt3", frame_cnt, 3);
    check("pol_f0", pol_hist[0], 1);
    check("pol_f1", pol_hist[1], 0);
    check("pol_f2", pol_hist[2], 0);

    mode = 1;
    bus.out_ready  = 1'b1;
    bus.data_valid = 1'b1;
    nb_count = 0;
    repeat (5) begin
      step();
      if (new_beat) nb_count++;
    end
    check("gap_busy", busy, 1);
    n = 0;
    while (busy && n < 100) begin
      step();
      if (new_beat) nb_count++;
      n++;
    end
    check("idle_busy", busy, 0);
    repeat (4) begin
      step();
      if (new_beat) nb_count++;
    end
    check("idle_no_beats", nb_count, 0);
    check("idle_valid", bus.out_valid, 0);

    // Frame 4 interrupted by asynchronous reset at bin 40
    enable = 1'b1;
    mode = 2;
    run_until_bin(40, 2000, "frame4_bin40");
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("rst_async");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    mode = 1;
    bus.data_valid = 1'b1;
    bus.out_ready  = 1'b1;
    run_until_bin(0, 50, "restart_sof");
    check("restart_pol", pol_hist[pol_hist.size() - 1], 1);
    run_until_frames(1, 300, "restart_frame_done");
    check("restart_fcnt", frame_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
